// File: rtl/arb_pkg.sv
// Shared types and defaults for the requester side of the multi-master arbiter.
package arb_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, XFER} agent_state_t;

   localparam int NUM_MASTER_DEF = 4;
   localparam int LEN_W_DEF      = 4;

endpackage

// File: rtl/arb_req_agent.sv
// One requester agent: holds a burst command, requests until L+1 beats are granted,
// tracks time spent waiting for grant.
//
// state | meaning
// IDLE  | no command held, req low, ready for a new command
// WAIT  | requesting, not holding grant (never granted yet, or preempted)
// XFER  | requesting and holding grant, beats being counted down
module arb_req_agent
   import arb_pkg::*;
#(
   parameter int LEN_W   = LEN_W_DEF,
   parameter int TIMEOUT = 16,
   parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             accept,
   input  logic [LEN_W-1:0] len,
   input  logic             pri_in,
   input  logic             grant_i,
   output logic             req_o,
   output logic             pri_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             starve_o,
   output logic             idle_o
);

   agent_state_t     state;
   logic [LEN_W-1:0] cnt;
   logic [TO_W-1:0]  wait_cnt;

   assign idle_o = (state == IDLE);

   // pri_o doubles as the stored priority bit: it is only nonzero while requesting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         wait_cnt <= '0;
         req_o    <= 1'b0;
         pri_o    <= 1'b0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         starve_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state    <= WAIT;
                  cnt      <= len;
                  wait_cnt <= '0;
                  req_o    <= 1'b1;
                  pri_o    <= pri_in;
               end
            end
            WAIT: begin
               if (grant_i) begin
                  if (cnt == '0) begin
                     state  <= IDLE;
                     req_o  <= 1'b0;
                     pri_o  <= 1'b0;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                  end else begin
                     cnt    <= cnt - LEN_W'(1);
                     state  <= XFER;
                     busy_o <= 1'b1;
                  end
               end else if (wait_cnt != TO_W'(TIMEOUT)) begin
                  wait_cnt <= wait_cnt + TO_W'(1);
                  if (wait_cnt == TO_W'(TIMEOUT - 1))
                     starve_o <= 1'b1;
               end
            end
            XFER: begin
               if (grant_i) begin
                  if (cnt == '0) begin
                     state  <= IDLE;
                     req_o  <= 1'b0;
                     pri_o  <= 1'b0;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                  end else begin
                     cnt <= cnt - LEN_W'(1);
                  end
               end else begin
                  // preempted: keep remaining beats, restart the starvation clock
                  state    <= WAIT;
                  wait_cnt <= '0;
                  busy_o   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/arb_requester_bank.sv
// Bank of requester agents facing the arbiter: command demux by master index,
// ready mux, and a sticky grant-legality checker.
module arb_requester_bank
   import arb_pkg::*;
#(
   parameter int num_master = NUM_MASTER_DEF,
   parameter int LEN_W      = LEN_W_DEF,
   parameter int TIMEOUT    = 16,
   parameter int TO_W       = $clog2(TIMEOUT + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   input  logic [$clog2(num_master)-1:0] cmd_id,
   input  logic [LEN_W-1:0]              cmd_len,
   input  logic                          cmd_pri,
   output logic                          cmd_ready,
   output logic [num_master-1:0]         req,
   output logic [num_master-1:0]         pri,
   input  logic [num_master-1:0]         grant,
   output logic [num_master-1:0]         busy,
   output logic [num_master-1:0]         done,
   output logic [num_master-1:0]         starve,
   output logic                          proto_err
);

   logic [num_master-1:0] idle;
   logic [num_master-1:0] accept;
   logic                  grant_illegal;

   always_comb begin
      accept    = '0;
      cmd_ready = 1'b0;
      if (int'(cmd_id) < num_master) begin
         cmd_ready      = idle[cmd_id];
         accept[cmd_id] = cmd_valid & idle[cmd_id];
      end
   end

   // more than one grant bit, or a grant to a master that is not requesting
   assign grant_illegal = ((grant & (grant - num_master'(1))) != '0) ||
                          ((grant & ~req) != '0);

   always_ff @(posedge clk) begin
      if (rst)
         proto_err <= 1'b0;
      else if (grant_illegal)
         proto_err <= 1'b1;
   end

   for (genvar g = 0; g < num_master; g++) begin : g_agent
      arb_req_agent #(
         .LEN_W   (LEN_W),
         .TIMEOUT (TIMEOUT),
         .TO_W    (TO_W)
      ) u_agent (
         .clk      (clk),
         .rst      (rst),
         .accept   (accept[g]),
         .len      (cmd_len),
         .pri_in   (cmd_pri),
         .grant_i  (grant[g]),
         .req_o    (req[g]),
         .pri_o    (pri[g]),
         .busy_o   (busy[g]),
         .done_o   (done[g]),
         .starve_o (starve[g]),
         .idle_o   (idle[g])
      );
   end

endmodule

// File: tb/tb_arb_requester_bank.sv
// Directed bench for arb_requester_bank with default parameters (4 masters, TIMEOUT=16).
module tb_arb_requester_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic [1:0] cmd_id;
   logic [3:0] cmd_len;
   logic       cmd_pri;
   logic       cmd_ready;
   logic [3:0] req, pri, grant, busy, done, starve;
   logic       proto_err;

   int total = 0;
   int bad   = 0;

   arb_requester_bank dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_id    (cmd_id),
      .cmd_len   (cmd_len),
      .cmd_pri   (cmd_pri),
      .cmd_ready (cmd_ready),
      .req       (req),
      .pri       (pri),
      .grant     (grant),
      .busy      (busy),
      .done      (done),
      .starve    (starve),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] id, input logic [3:0] len, input logic p);
      cmd_valid = 1'b1;
      cmd_id    = id;
      cmd_len   = len;
      cmd_pri   = p;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b1; cmd_id = 2'd0; cmd_len = 4'd0; cmd_pri = 1'b0; grant = 4'b0000;

      // reset with a command present: nothing may be accepted
      tick(); tick();
      chk("rst_req", req, 4'b0000);
      chk("rst_done", done, 4'b0000);
      chk("rst_busy", busy, 4'b0000);
      chk("rst_starve", starve, 4'b0000);
      chk("rst_perr", proto_err, 1'b0);
      rst = 1'b0; cmd_valid = 1'b0;
      #1;
      chk("rst_ready", cmd_ready, 1'b1);

      // single beat on master 1
      cmd_valid = 1'b1; cmd_id = 2'd1; cmd_len = 4'd0; cmd_pri = 1'b1;
      #1;
      chk("sb_ready", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      chk("sb_req", req, 4'b0010);
      chk("sb_pri", pri, 4'b0010);
      chk("sb_busy0", busy, 4'b0000);
      grant = 4'b0010;
      tick();
      grant = 4'b0000;
      chk("sb_req_drop", req, 4'b0000);
      chk("sb_pri_drop", pri, 4'b0000);
      chk("sb_done", done, 4'b0010);
      chk("sb_busy1", busy, 4'b0000);
      tick();
      chk("sb_done_clr", done, 4'b0000);
      chk("sb_perr", proto_err, 1'b0);

      // preempted 4-beat burst on master 2, priority 0
      issue(2'd2, 4'd3, 1'b0);
      #1;
      chk("pb_ready_busy", cmd_ready, 1'b0);
      chk("pb_req", req, 4'b0100);
      chk("pb_pri", pri, 4'b0000);
      grant = 4'b0100;
      tick();
      chk("pb_busy_b1", busy, 4'b0100);
      tick();
      chk("pb_busy_b2", busy, 4'b0100);
      grant = 4'b0000;
      tick();
      chk("pb_busy_gap", busy, 4'b0000);
      chk("pb_req_gap", req, 4'b0100);
      tick(); tick();
      chk("pb_busy_gap3", busy, 4'b0000);
      chk("pb_done_gap", done, 4'b0000);
      grant = 4'b0100;
      tick();
      chk("pb_busy_b3", busy, 4'b0100);
      chk("pb_done_b3", done, 4'b0000);
      tick();
      grant = 4'b0000;
      chk("pb_done_b4", done, 4'b0100);
      chk("pb_req_end", req, 4'b0000);
      chk("pb_starve", starve, 4'b0000);
      chk("pb_perr", proto_err, 1'b0);

      // starvation on master 0: flag exactly 16 cycles after req rises
      issue(2'd0, 4'd0, 1'b0);
      chk("st_req", req, 4'b0001);
      for (int i = 0; i < 15; i++) tick();
      chk("st_before", starve, 4'b0000);
      tick();
      chk("st_at", starve, 4'b0001);
      grant = 4'b0001;
      tick();
      grant = 4'b0000;
      chk("st_done", done, 4'b0001);
      tick();
      chk("st_sticky", starve, 4'b0001);

      // back-to-back on master 3: re-issue in the done cycle
      issue(2'd3, 4'd0, 1'b0);
      grant = 4'b1000;
      tick();
      grant = 4'b0000;
      chk("bb_done", done, 4'b1000);
      chk("bb_req_gap", req, 4'b0000);
      cmd_valid = 1'b1; cmd_id = 2'd3; cmd_len = 4'd1; cmd_pri = 1'b1;
      #1;
      chk("bb_ready", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      chk("bb_req_back", req, 4'b1000);
      chk("bb_pri_back", pri, 4'b1000);
      grant = 4'b1000;
      tick();
      chk("bb_busy", busy, 4'b1000);
      tick();
      grant = 4'b0000;
      chk("bb_done2", done, 4'b1000);
      chk("bb_perr", proto_err, 1'b0);

      // two grant bits while both masters request: error, but both still count beats
      issue(2'd1, 4'd1, 1'b0);
      issue(2'd2, 4'd1, 1'b0);
      chk("pe_req", req, 4'b0110);
      grant = 4'b0110;
      tick();
      grant = 4'b0000;
      chk("pe_multi", proto_err, 1'b1);
      chk("pe_busy", busy, 4'b0110);

      // reset mid-transfer abandons silently
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("pe_rst_perr", proto_err, 1'b0);
      chk("pe_rst_req", req, 4'b0000);
      chk("pe_rst_starve", starve, 4'b0000);
      tick();
      chk("pe_rst_done", done, 4'b0000);

      // grant to a non-requesting master
      grant = 4'b1000;
      tick();
      grant = 4'b0000;
      chk("pe_noreq", proto_err, 1'b1);
      chk("pe_a3_req", req, 4'b0000);
      chk("pe_a3_done", done, 4'b0000);
      chk("pe_a3_busy", busy, 4'b0000);

      // grant in the accept cycle is ignored and flagged
      rst = 1'b1;
      tick();
      rst = 1'b0;
      grant = 4'b1000;
      issue(2'd3, 4'd0, 1'b0);
      grant = 4'b0000;
      chk("ga_perr", proto_err, 1'b1);
      chk("ga_req", req, 4'b1000);
      chk("ga_done", done, 4'b0000);
      grant = 4'b1000;
      tick();
      grant = 4'b0000;
      chk("ga_done2", done, 4'b1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/arb_requester_bank.md
Name: arb_requester_bank

Overview:
- Requester side of the team's multi-master arbiter protocol (req/pri out, grant in).
- Holds one requester agent per master. Each agent accepts a transfer command and raises req with a priority bit. It counts granted beats, drops req when the transfer completes, and pulses done.
- Also monitors grant legality and per-master starvation.
- Sits between command sources and the arbiter; req/pri/grant connect bit-for-bit to the arbiter's req/pri/grant.

Parameters:
- num_master, 4, number of masters; width of req/pri/grant.
- LEN_W, 4, width of the beat-length field; command value L means L+1 beats.
- TIMEOUT, 16, cycles spent in WAIT before starve is flagged; must be >= 1.
- TO_W, $clog2(TIMEOUT+1), width of the watchdog counter.

Ports:
- clk  in  1  clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_id  in  $clog2(num_master)  target master index.
- cmd_len  in  LEN_W  beats minus one.
- cmd_pri  in  1  priority bit to present while requesting.
- cmd_ready  out  1  the targeted agent is IDLE; combinational from cmd_id.
- req  out  num_master  request to the arbiter.
- pri  out  num_master  priority to the arbiter.
- grant  in  num_master  grant from the arbiter; sampled at clk.
- busy  out  num_master  agent is in XFER.
- done  out  num_master  one-cycle completion pulse.
- starve  out  num_master  sticky: WAIT reached TIMEOUT.
- proto_err  out  1  sticky: illegal grant observed.

Behaviour:
- Reset, synchronous active-high on rst at a clk edge: all agents go to IDLE; cnt=0, wait_cnt=0. req, pri, busy, done, starve, proto_err are all 0 from the next cycle. Reset mid-transfer abandons the transfer silently, with no done.
- Per-agent states:
  - IDLE: req=0.
  - WAIT: req=1, not yet granted, or grant lost.
  - XFER: req=1, holding grant.
- All outputs are registered except cmd_ready.
- pri[i] = pri_r[i] when req[i]=1, else 0.
- Command accept: cmd_valid & cmd_ready. Agent cmd_id loads cnt<=cmd_len, pri_r<=cmd_pri, wait_cnt<=0, and goes IDLE->WAIT. req is asserted the cycle after accept.
- cmd_ready=0 when the agent at cmd_id is not IDLE; the command is then held by the source.
- Beat: an edge at which req[i]=1 and grant[i]=1. Total beats per command = L+1.
- WAIT, grant[i]=1:
  - cnt==0: go to IDLE, done[i]<=1.
  - otherwise: cnt--, go to XFER.
- WAIT, grant[i]=0: wait_cnt++ (saturating). When wait_cnt reaches TIMEOUT, starve[i]<=1 (sticky until rst).
- XFER, grant[i]=1: cnt==0 -> IDLE plus done; otherwise cnt--.
- XFER, grant[i]=0 (preemption): go to WAIT, keep cnt, clear wait_cnt. req stays 1 and the transfer resumes on the next grant.
- done[i] is high exactly in the first IDLE cycle. A new command to the same master may be accepted in that cycle.
- L=0: a single beat. WAIT->IDLE directly; busy never asserts.
- Simultaneous completion on several masters: each done bit pulses independently.
- proto_err<=1 (sticky) at any edge where either condition holds:
  - grant is not one-hot-or-zero; or
  - grant[i]=1 while req[i]=0.
- Illegal grant bits still count as beats for agents whose req is 1.
- Grant arriving in the same cycle as accept: ignored, because req is still 0; this also raises proto_err.

Decomposition:
- Package arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT, XFER} agent_state_t;
  - localparam defaults for num_master and LEN_W.
- Sub-module arb_req_agent: one FSM per master, instantiated num_master times via generate. Ports: clk, rst, accept, len, pri_in, grant_i, req_o, pri_o, busy_o, done_o, starve_o, idle_o.
- Top level holds the cmd_id demux, cmd_ready mux, and proto_err checker.

Test Plan:
- Reset: rst=1 for 2 cycles with cmd_valid=1 -> req=0000, done=0, proto_err=0, cmd_ready=1 after rst falls.
- Single beat: cmd id=1, len=0, pri=1; grant=0010 the cycle after req[1] rises -> req=0010, pri=0010 for 1 cycle; done=0010 pulse next cycle; busy never 1.
- Preempted burst: cmd id=2, len=3; grant[2] for 2 cycles, 0 for 3 cycles, then 1 for 2 cycles -> busy[2] drops during the gap; exactly 4 beats; done[2] after the 4th beat; starve=0.
- Starvation: cmd id=0, grant held 0000 -> starve[0]=1 exactly TIMEOUT cycles after req[0] rises; stays 1 after a later grant and done.
- Back-to-back: re-issue a cmd to id=3 in its done cycle -> accepted (cmd_ready=1); req[3] drops for 1 cycle only.
- Protocol error: grant=0110 with req=0110 -> proto_err=1 next cycle. Also grant=1000 with req[3]=0 -> proto_err=1, and agent 3 is unaffected.
